// File: rtl/uart_tx_fifo_if.sv
// Byte-write side and transmitter handshake of uart_tx_fifo.
// slave is the FIFO; master is its environment (writer plus transmitter).
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    logic                   wr_e_i;
    logic [7:0]             wr_d_i;
    logic                   full_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   overflow_o;
    logic                   idle_o;
    logic                   tx_e_o;
    logic [7:0]             tx_d_o;
    logic                   tx_busy_i;

    modport master (
        output wr_e_i, wr_d_i, tx_busy_i,
        input  full_o, count_o, overflow_o, idle_o, tx_e_o, tx_d_o
    );
    modport slave (
        input  wr_e_i, wr_d_i, tx_busy_i,
        output full_o, count_o, overflow_o, idle_o, tx_e_o, tx_d_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO ahead of the UART transmitter. Drains one byte per
// enable pulse and relaunches a byte if busy never rises.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    state_t        state;
    logic          tx_e, overflow;
    logic [7:0]    tx_d;
    logic          full, push, pop;

    // Full is taken from the pre-edge count, so a pop never frees room
    // for a write in the same cycle.
    assign full = (count == CW'(DEPTH));
    assign push = bus.wr_e_i && !full;
    assign pop  = (state == IDLE) && (count != '0) && !bus.tx_busy_i;

    assign bus.full_o     = full;
    assign bus.count_o    = count;
    assign bus.overflow_o = overflow;
    assign bus.idle_o     = (count == '0) && (state == IDLE);
    assign bus.tx_e_o     = tx_e;
    assign bus.tx_d_o     = tx_d;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_d_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_d     <= 8'h00;
            tx_e     <= 1'b0;
            timer    <= '0;
            state    <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                tx_d   <= mem[rd_ptr];
            end
            count <= count + CW'(push) - CW'(pop);
            if (bus.wr_e_i && full) overflow <= 1'b1;

            tx_e <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= LAUNCH;
                        tx_e  <= 1'b1;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy_i) begin
                        state <= WAIT_DONE;
                    end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                        state <= LAUNCH;   // same byte, no new pop
                        tx_e  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
